// File: rtl/periph_bus_arbiter_pkg.sv
// Shared definitions for the peripheral bus arbiter: FSM encoding,
// the LED GPIO base address and a one-hot to index helper.
package periph_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } arb_state_e;

  localparam logic [31:0] LED_BASE = 32'h1000_0000;

  // Widest requester vector the index helper understands.
  localparam int MAX_REQ = 32;

  // Index of the set bit in a one-hot vector (0 when no bit is set).
  function automatic logic [4:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/periph_bus_arbiter_rr.sv
// Combinational round-robin grant: the first requester at or after ptr,
// wrapping past the top index, receives a one-hot grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic found;
  int   pos;

  // Walk the requesters in priority order starting at ptr and grant the first one.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == pos) && req_i[j]) begin
          gnt_o[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Shares one GPIO-style register port between NUM_REQ bus masters.
// One peripheral access per grant, round-robin between masters; the read
// and write strobes are only driven in ISSUE and never together.
module periph_bus_arbiter
  import periph_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      m_req,
  input  logic [NUM_REQ-1:0]      m_rd,
  input  logic [NUM_REQ*AW-1:0]   m_addr,
  input  logic [NUM_REQ*DW-1:0]   m_wdata,
  input  logic [NUM_REQ*DW/8-1:0] m_wstrb,
  output logic [NUM_REQ-1:0]      m_ack,
  output logic [DW-1:0]           m_rdata,
  output logic                    busy,
  output logic [AW-1:0]           p_addr,
  output logic [DW-1:0]           p_data_in,
  output logic                    p_rd_strobe,
  output logic [DW/8-1:0]         p_wr_strobe,
  input  logic [DW-1:0]           p_data_out
);

  localparam int SW = DW / 8;
  localparam int PW = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] gnt_q;
  logic               rd_q;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      wdata_q;
  logic [SW-1:0]      wstrb_q;
  logic [DW-1:0]      rdata_q;
  logic [4:0]         g_idx;

  logic               sel_rd;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;
  logic [SW-1:0]      sel_wstrb;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (m_req),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  // Pick the payload of the granted master out of the flattened buses.
  always_comb begin
    sel_rd    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_rd    = m_rd[i];
        sel_addr  = m_addr[i*AW +: AW];
        sel_wdata = m_wdata[i*DW +: DW];
        sel_wstrb = m_wstrb[i*SW +: SW];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: reads take the extra CAPTURE cycle for registered peripheral data.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (|m_req) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = rd_q ? ST_CAPTURE : ST_ACK;
      ST_CAPTURE: state_d = ST_ACK;
      ST_ACK:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: strobes only in ISSUE, ack only in ACK.
  always_comb begin
    m_ack       = '0;
    p_rd_strobe = 1'b0;
    p_wr_strobe = '0;
    busy        = (state_q != ST_IDLE);
    if (state_q == ST_ISSUE) begin
      if (rd_q) p_rd_strobe = 1'b1;
      else      p_wr_strobe = wstrb_q;
    end
    if (state_q == ST_ACK) m_ack = gnt_q;
  end

  // Round-robin pointer moves to the master after the one just acknowledged.
  always_comb begin
    g_idx = oh_to_idx(MAX_REQ'(gnt_q));
    ptr_d = ptr_q;
    if (state_q == ST_ACK) begin
      ptr_d = (int'(g_idx) == NUM_REQ - 1) ? '0 : PW'(g_idx + 5'd1);
    end
  end

  // Grant/payload latches, captured read data and the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      gnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (state_q == ST_IDLE && |m_req) begin
        gnt_q   <= gnt;
        rd_q    <= sel_rd;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        wstrb_q <= sel_wstrb;
      end
      if (state_q == ST_CAPTURE) rdata_q <= p_data_out;
    end
  end

  assign m_rdata   = rdata_q;
  assign p_addr    = addr_q;
  assign p_data_in = wdata_q;

endmodule
